// File: rtl/pixel_gray_pipe.sv
// pixel_gray_pipe: three-stage RGB to gray converter with valid/ready flow control
module pixel_gray_pipe #(
  parameter int N = 32,
  parameter int CW = 8,
  parameter bit REPLICATE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_mode,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [15:0]  out_count
);
  localparam int SW = CW + 2;
  localparam int LW = CW + 8;
  localparam int K = CW + 4;
  localparam int PW = SW + K;
  // ceil(2^K/3): with K = SW+2 the reciprocal product is exact for every SW-bit sum
  localparam longint unsigned RECIP_L = ((64'd1 << K) + 64'd2) / 64'd3;
  localparam logic [PW-1:0] RECIP = PW'(RECIP_L);
  logic [CW-1:0] in_r, in_g, in_b;
  logic [SW-1:0] s1_sum_d, s1_sum_q;
  logic [LW-1:0] s1_luma_d, s1_luma_q;
  logic [CW-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic [1:0]    s1_mode_q;
  logic          s1_valid_q, s1_last_q;
  logic [PW-1:0] mean_prod;
  logic [CW-1:0] mean, luma, mx, mn, s2_y_d, s2_y_q;
  logic          s2_valid_q, s2_last_q;
  logic [N-1:0]  out_data_d, out_data_q;
  logic          out_valid_q, out_last_q, advance;
  logic [15:0]   out_count_d, out_count_q;
  logic          unused_bits;
  assign in_b = in_data[CW-1:0];
  assign in_g = in_data[2*CW-1:CW];
  assign in_r = in_data[3*CW-1:2*CW];
  assign advance = out_ready | ~out_valid_q;
  assign in_ready = advance;
  assign s1_sum_d = SW'(in_r) + SW'(in_g) + SW'(in_b);
  assign s1_luma_d = LW'(in_r) * LW'(77) + LW'(in_g) * LW'(150) + LW'(in_b) * LW'(29);
  assign mean_prod = PW'(s1_sum_q) * RECIP;
  assign mean = mean_prod[K+CW-1:K];
  assign luma = s1_luma_q[LW-1:8];
  assign mx = (s1_r_q > s1_g_q) ? ((s1_r_q > s1_b_q) ? s1_r_q : s1_b_q) : ((s1_g_q > s1_b_q) ? s1_g_q : s1_b_q);
  assign mn = (s1_r_q < s1_g_q) ? ((s1_r_q < s1_b_q) ? s1_r_q : s1_b_q) : ((s1_g_q < s1_b_q) ? s1_g_q : s1_b_q);
  assign s2_y_d = (s1_mode_q == 2'd0) ? mean : (s1_mode_q == 2'd1) ? luma : (s1_mode_q == 2'd2) ? mx : mn;
  assign out_data_d = REPLICATE ? N'({3{s2_y_q}}) : N'(s2_y_q);
  assign out_count_d = (out_valid_q && out_ready) ? (out_last_q ? 16'd0 : out_count_q + 16'd1) : out_count_q;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign out_count = out_count_q;
  assign unused_bits = ^{in_data, mean_prod, s1_luma_q[7:0]};
  // Pipeline stages: all load together whenever the output can advance, else hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= 2'd0;
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      s1_b_q      <= '0;
      s1_sum_q    <= '0;
      s1_luma_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_y_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_last_q   <= in_last;
      s1_mode_q   <= in_mode;
      s1_r_q      <= in_r;
      s1_g_q      <= in_g;
      s1_b_q      <= in_b;
      s1_sum_q    <= s1_sum_d;
      s1_luma_q   <= s1_luma_d;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_y_q      <= s2_y_d;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_last_q;
      out_data_q  <= out_data_d;
    end
  end
  // Output transfers per frame; the transfer carrying out_last restarts the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_count_q <= 16'd0;
    else out_count_q <= out_count_d;
  end
endmodule

// File: tb/tb_pixel_gray_pipe.sv
// tb_pixel_gray_pipe: directed checks of the gray pipeline, both lane formats
module tb_pixel_gray_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        in_valid, in_last, out_ready;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic        in_ready0, out_valid0, out_last0;
  logic [31:0] out_data0;
  logic [15:0] out_count0;
  int tests = 0;
  int fails = 0;
  logic [31:0] tp [18];
  logic [1:0]  tm [18];
  logic [31:0] te [18];
  logic [31:0] sp [5];
  logic [1:0]  sm [5];
  logic [31:0] se [5];
  logic [31:0] mp [966];
  logic [31:0] me [966];

  always #5 clk = ~clk;

  pixel_gray_pipe #(.N(32), .CW(8), .REPLICATE(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .out_count(out_count)
  );

  pixel_gray_pipe #(.N(32), .CW(8), .REPLICATE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_last(out_last0), .out_ready(out_ready), .out_count(out_count0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] m, input logic l);
    in_valid = v;
    in_data = d;
    in_mode = m;
    in_last = l;
  endtask

  initial begin
    int idx, got, k;
    logic acc, xfer, lst;
    logic [7:0] r, g, b;
    tp = '{32'h00302010, 32'h00302010, 32'h00302010, 32'h00302010,
           32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF,
           32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
           32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'hAB302010,
           32'h00051A09, 32'h00051A09};
    tm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
           2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
    te = '{32'h00202020, 32'h00232323, 32'h00303030, 32'h00101010,
           32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF,
           32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
           32'h004C4C4C, 32'h00959595, 32'h001C1C1C, 32'h00202020,
           32'h001A1A1A, 32'h00050505};
    sp = '{32'h00090603, 32'h00302010, 32'h00302010, 32'h00302010, 32'h00FFFFFF};
    sm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    se = '{32'h00060606, 32'h00232323, 32'h00303030, 32'h00101010, 32'h00FFFFFF};
    for (int s = 0; s < 966; s++) begin
      if (s < 766) begin
        r = (s > 255) ? 8'd255 : 8'(s);
        g = ((s - int'(r)) > 255) ? 8'd255 : 8'(s - int'(r));
        b = 8'(s - int'(r) - int'(g));
      end else begin
        r = 8'($urandom_range(255));
        g = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
      end
      mp[s] = {8'h00, r, g, b};
      me[s] = {8'h00, {3{8'((int'(r) + int'(g) + int'(b)) / 3)}}};
    end

    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Mode sequence and boundary pixels back to back; results emerge after the third edge counting the accept edge
    for (int c = 0; c < 20; c++) begin
      if (c < 18) drive(1'b1, tp[c], tm[c], 1'b0);
      else drive(1'b0, 32'h0, 2'd0, 1'b0);
      cyc();
      if (c == 1) check("latency_not_early", 32'(out_valid), 32'd0);
      if (c >= 2) begin
        check($sformatf("vec%0d_valid", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d_data", c - 2), out_data, te[c-2]);
      end
      if (c == 2) check("rep0_mean", out_data0, 32'h00000020);
      if (c == 6) check("rep0_white", out_data0, 32'h000000FF);
    end
    cyc();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: stall the output while streaming 5 pixels, then release
    idx = 0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 5) drive(1'b1, sp[idx], sm[idx], 1'b0);
      else drive(1'b0, 32'h0, 2'd0, 1'b0);
      out_ready = !(c >= 1 && c < 8);
      #1;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (c >= 4 && c < 8) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_frozen", out_data, se[0]);
      end
      if (xfer) begin
        if (got < 5) check($sformatf("stall_order%0d", got), out_data, se[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    check("stall_accepted", 32'(idx), 32'd5);
    check("stall_delivered", 32'(got), 32'd5);

    // Reset with two pixels in flight
    out_ready = 1'b1;
    drive(1'b1, 32'h00302010, 2'd0, 1'b0);
    cyc();
    cyc();
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    check("pre_rst_count", 32'(out_count), 32'd23);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_count", 32'(out_count), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    cyc();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("no_stale", 32'(out_valid), 32'd0);
    end
    drive(1'b1, 32'h00090603, 2'd0, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 2'd0, 1'b0);
    cyc();
    check("post_rst_not_early", 32'(out_valid), 32'd0);
    cyc();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", out_data, 32'h00060606);
    check("post_rst_last", 32'(out_last), 32'd1);
    cyc();
    check("post_rst_count", 32'(out_count), 32'd0);

    // Frame of 4 pixels, last on the 4th
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive(1'b1, 32'h00302010, 2'd2, c == 3);
      else drive(1'b0, 32'h0, 2'd0, 1'b0);
      xfer = out_valid && out_ready;
      lst = out_last;
      if (xfer) check($sformatf("frame_last%0d", k), 32'(lst), (k == 3) ? 32'd1 : 32'd0);
      cyc();
      if (xfer) begin
        k++;
        check($sformatf("frame_count%0d", k), 32'(out_count), (k == 4) ? 32'd0 : 32'(k));
      end
    end
    check("frame_xfers", 32'(k), 32'd4);

    // Mean mode over every channel sum 0..765 plus random pixels
    for (int c = 0; c < 968; c++) begin
      if (c < 966) drive(1'b1, mp[c], 2'd0, 1'b0);
      else drive(1'b0, 32'h0, 2'd0, 1'b0);
      cyc();
      if (c >= 2) check($sformatf("mean%0d", c - 2), out_data, me[c-2]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
